// File: rtl/sha256_pkg.sv
// sha256_pkg: constants, types and helper functions shared by the SHA-256
// message-schedule slice.
//   - word width / round count / window depth
//   - schedule FSM state type
//   - initial hash values H0..H7
//   - round constants K[0..63] (only present when SHA256_SCHED_KADD_EN is defined)
//   - sigma0 / sigma1 small-sigma functions
package sha256_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned ROUNDS    = 64;
  localparam int unsigned WIN_WORDS = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } sched_state_t;

  localparam word_t H_INIT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

`ifdef SHA256_SCHED_KADD_EN
  localparam word_t K [ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
`endif

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_sched_word.sv
// sha256_sched_word: combinational next-word computation for the schedule.
//   w_t    in  32  W[t]
//   w_t1   in  32  W[t+1]
//   w_t9   in  32  W[t+9]
//   w_t14  in  32  W[t+14]
//   w_new  out 32  W[t+16] = sigma1(W[t+14]) + W[t+9] + sigma0(W[t+1]) + W[t] mod 2^32
module sha256_sched_word
  import sha256_pkg::*;
(
  input  logic [31:0] w_t,
  input  logic [31:0] w_t1,
  input  logic [31:0] w_t9,
  input  logic [31:0] w_t14,
  output logic [31:0] w_new
);

  always_comb begin
    w_new = sigma1(w_t14) + w_t9 + sigma0(w_t1) + w_t;
  end

endmodule

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: SHA-256 message schedule generator.
// Accepts one padded 512-bit block and streams W[0..63] one word per
// transfer (w_valid && w_ready), holding all outputs while stalled.
//   clk        in   1    clock, rising edge
//   rst        in   1    synchronous active-high reset
//   blk_valid  in   1    block offered
//   blk_ready  out  1    block accepted on blk_valid && blk_ready
//   blk_data   in   512  block, W[0] in bits [511:480]
//   w_valid    out  1    w_out holds a schedule word
//   w_ready    in   1    consumer takes the word
//   w_out      out  32   W[t]
//   w_idx      out  6    t
//   w_last     out  1    t == 63
//   busy       out  1    block in flight
//   wk_out     out  32   W[t] + K[t] (only with SHA256_SCHED_KADD_EN defined)
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_out,
  output logic [5:0]   w_idx,
  output logic         w_last,
  output logic         busy
`ifdef SHA256_SCHED_KADD_EN
  ,
  output logic [31:0]  wk_out
`endif
);

  sched_state_t state, state_nxt;
  word_t        win [WIN_WORDS];
  word_t        w_new;
  logic         rst_q;
  logic         accept;
  logic         xfer;
  logic         final_xfer;

  sha256_sched_word u_word (
    .w_t   (win[0]),
    .w_t1  (win[1]),
    .w_t9  (win[9]),
    .w_t14 (win[14]),
    .w_new (w_new)
  );

  // rst_q keeps blk_ready low for one cycle after reset is released.
  always_comb begin
    state_nxt  = state;
    blk_ready  = 1'b0;
    busy       = 1'b0;
    w_valid    = 1'b0;
    accept     = 1'b0;
    xfer       = 1'b0;
    final_xfer = 1'b0;
    case (state)
      ST_IDLE: begin
        blk_ready = !rst_q;
        accept    = blk_valid && !rst_q;
        if (accept) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy       = 1'b1;
        w_valid    = 1'b1;
        xfer       = w_ready;
        final_xfer = w_ready && (w_idx == 6'd63);
        if (final_xfer) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      rst_q  <= 1'b1;
      w_out  <= '0;
      w_idx  <= '0;
      w_last <= 1'b0;
    end else begin
      state <= state_nxt;
      rst_q <= 1'b0;
      if (accept) begin
        w_out  <= blk_data[511:480];
        w_idx  <= '0;
        w_last <= 1'b0;
      end else if (xfer) begin
        // win[1] is the word that becomes win[0] after this shift.
        if (!final_xfer) begin
          w_out  <= win[1];
          w_idx  <= w_idx + 6'd1;
          w_last <= (w_idx == 6'd62);
        end else begin
          w_last <= 1'b0;
        end
      end
    end
  end

`ifdef SHA256_SCHED_KADD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wk_out <= '0;
    end else if (accept) begin
      wk_out <= blk_data[511:480] + K[0];
    end else if (xfer && !final_xfer) begin
      wk_out <= win[1] + K[w_idx + 6'd1];
    end
  end
`endif

  // The window needs no reset: it is fully reloaded on every acceptance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) begin
        for (int unsigned i = 0; i < WIN_WORDS; i++) begin
          win[i] <= blk_data[511 - 32*i -: 32];
        end
      end else if (xfer) begin
        for (int unsigned i = 0; i < WIN_WORDS - 1; i++) begin
          win[i] <= win[i+1];
        end
        win[WIN_WORDS-1] <= w_new;
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb_sha256_msg_schedule: directed self-checking bench for sha256_msg_schedule.
// Covers reset values, the "abc" schedule with free-running and stalling
// consumer, mid-block reset, continuous blk_valid spacing and a carry-heavy
// all-ones block against an in-bench reference schedule.
module tb_sha256_msg_schedule;

  logic         clk;
  logic         rst;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_out;
  logic [5:0]   w_idx;
  logic         w_last;
  logic         busy;
`ifdef SHA256_SCHED_KADD_EN
  logic [31:0]  wk_out;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_w [64];

  localparam logic [511:0] BLK_ABC  = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_ONES = {512{1'b1}};

  sha256_msg_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_out     (w_out),
    .w_idx     (w_idx),
    .w_last    (w_last),
    .busy      (busy)
`ifdef SHA256_SCHED_KADD_EN
    ,
    .wk_out    (wk_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_model(input logic [511:0] b);
    for (int t = 0; t < 16; t++) exp_w[t] = b[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      exp_w[t] = ss1(exp_w[t-2]) + exp_w[t-7] + ss0(exp_w[t-15]) + exp_w[t-16];
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers block b, then consumes all 64 words, checking every presented cycle.
  task automatic run_block(input logic [511:0] b, input bit rnd, input string tag);
    int k;
    int cyc;
    logic rdy;
    build_model(b);
    chk({tag, "_ready_before"}, blk_ready, 1);
    blk_data  = b;
    blk_valid = 1'b1;
    w_ready   = 1'b0;
    tick();
    blk_valid = 1'b0;
    k   = 0;
    cyc = 0;
    while (k < 64 && cyc < 1000) begin
      chk({tag, "_valid"}, w_valid, 1);
      chk({tag, "_idx"}, w_idx, k);
      chk({tag, "_word"}, w_out, exp_w[k]);
      chk({tag, "_last"}, w_last, (k == 63));
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_blk_ready_run"}, blk_ready, 0);
      if (k == 16 && b == BLK_ABC) chk({tag, "_w16"}, w_out, 32'h61626380);
      if (k == 17 && b == BLK_ABC) chk({tag, "_w17"}, w_out, 32'h000F0000);
`ifdef SHA256_SCHED_KADD_EN
      if (k == 0 && b == BLK_ABC) chk({tag, "_wk0"}, wk_out, 32'hA3EC9318);
`endif
      rdy     = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      w_ready = rdy;
      tick();
      cyc++;
      if (rdy) k++;
      if (bad > 40) break;
    end
    w_ready = 1'b0;
    chk({tag, "_words_done"}, k, 64);
    chk({tag, "_end_valid"}, w_valid, 0);
    chk({tag, "_end_last"}, w_last, 0);
    chk({tag, "_end_busy"}, busy, 0);
    chk({tag, "_end_blk_ready"}, blk_ready, 1);
  endtask

  initial begin
    int n;
    int acc_n;
    int last_acc;
    int k;
    logic pr;

    rst       = 1'b1;
    blk_valid = 1'b0;
    blk_data  = '0;
    w_ready   = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_w_valid", w_valid, 0);
    chk("rst_blk_ready", blk_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_w_last", w_last, 0);
    chk("rst_w_out", w_out, 0);
    chk("rst_w_idx", w_idx, 0);
`ifdef SHA256_SCHED_KADD_EN
    chk("rst_wk_out", wk_out, 0);
`endif
    rst = 1'b0;
    tick();
    chk("post_rst_blk_ready", blk_ready, 1);
    chk("post_rst_w_valid", w_valid, 0);

    // "abc" with consumer always ready, then with random stalls
    run_block(BLK_ABC, 1'b0, "abc");
    tick();
    run_block(BLK_ABC, 1'b1, "abc_stall");
    tick();

    // Reset in the middle of a block
    blk_data  = BLK_ABC;
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    w_ready   = 1'b1;
    n = 0;
    while (w_idx != 6'd30 && n < 200) begin
      tick();
      n++;
    end
    chk("mid_reach_30", w_idx, 30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_w_valid", w_valid, 0);
    chk("mid_rst_blk_ready", blk_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_w_idx", w_idx, 0);
    tick();
    chk("mid_rst_blk_ready_back", blk_ready, 1);
    chk("mid_rst_no_words", w_valid, 0);
    w_ready = 1'b0;
    tick();
    chk("mid_rst_still_idle", w_valid, 0);
    run_block(BLK_ABC, 1'b0, "after_rst");

    // Continuous blk_valid with an all-ones block: back-to-back, 65-cycle spacing
    build_model(BLK_ONES);
    blk_data  = BLK_ONES;
    blk_valid = 1'b1;
    w_ready   = 1'b1;
    acc_n    = 0;
    last_acc = 0;
    k        = 0;
    for (int c = 0; c < 200; c++) begin
      pr = blk_ready;
      tick();
      if (pr) begin
        if (acc_n > 0) chk("b2b_gap", c - last_acc, 65);
        chk("b2b_start_idx", k, 0);
        last_acc = c;
        acc_n++;
      end
      chk("b2b_no_overlap", blk_ready && w_valid, 0);
      if (w_valid) begin
        chk("b2b_idx", w_idx, k);
        chk("b2b_word", w_out, exp_w[k]);
        chk("b2b_last", w_last, (k == 63));
        k = (k == 63) ? 0 : k + 1;
      end
    end
    chk("b2b_accept_count", acc_n, 4);
    blk_valid = 1'b0;
    w_ready   = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
